// File: rtl/branch_predictor_btb_pkg.sv
// Shared types and helpers for the BTB branch predictor: 2-bit counter states,
// saturating counter steps and PC field extraction.
package bp_pkg;

   typedef logic [1:0] ctr2_t;

   localparam ctr2_t SNT = 2'b00;
   localparam ctr2_t WNT = 2'b01;
   localparam ctr2_t WT  = 2'b10;
   localparam ctr2_t ST  = 2'b11;

   // PCs are zero-extended to this width so one helper serves every XLEN.
   localparam int PC_MAX_W = 128;
   typedef logic [PC_MAX_W-1:0] pc_wide_t;

   function automatic ctr2_t sat_inc2(input ctr2_t c);
      return (c == ST) ? ST : ctr2_t'(c + 2'b01);
   endfunction

   function automatic ctr2_t sat_dec2(input ctr2_t c);
      return (c == SNT) ? SNT : ctr2_t'(c - 2'b01);
   endfunction

   function automatic pc_wide_t bp_idx(input pc_wide_t pc, input int idx_w);
      pc_wide_t mask;
      mask = (pc_wide_t'(1) << idx_w) - pc_wide_t'(1);
      return (pc >> 2) & mask;
   endfunction

   function automatic pc_wide_t bp_tag(input pc_wide_t pc, input int idx_w, input int tag_w);
      pc_wide_t mask;
      mask = (pc_wide_t'(1) << tag_w) - pc_wide_t'(1);
      return (pc >> (idx_w + 2)) & mask;
   endfunction

endpackage

// File: rtl/branch_predictor_btb_sat_counter.sv
// Saturating up-counter used for the branch and mispredict statistics;
// a clear wins over a same-cycle increment.
module bp_sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [CNT_W-1:0] o_count
);

   logic [CNT_W-1:0] r_count;

   // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_inc && (r_count != '1)) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit counters: combinational lookup on the fetch PC,
// training and mispredict detection at branch resolution, plus statistics.
module branch_predictor_btb
   import bp_pkg::*;
#(
   parameter int    XLEN     = 64,
   parameter int    ENTRIES  = 16,
   parameter int    TAG_W    = 8,
   parameter int    MODE     = 1,
   parameter ctr2_t CTR_INIT = 2'b01,
   parameter int    CNT_W    = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] fetch_pc,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,
   input  logic            upd_valid,
   input  logic [XLEN-1:0] upd_pc,
   input  logic            upd_taken,
   input  logic [XLEN-1:0] upd_target,
   input  logic            upd_pred_taken,
   input  logic [XLEN-1:0] upd_pred_target,
   output logic            mispredict,
   output logic [XLEN-1:0] redirect_pc,
   input  logic            flush_all,
   input  logic            clr_stats,
   output logic [CNT_W-1:0] branch_count,
   output logic [CNT_W-1:0] mispredict_count
);

   localparam int IDX_W = $clog2(ENTRIES);

   logic [ENTRIES-1:0] r_valid;
   logic [TAG_W-1:0]   r_tag [ENTRIES];
   logic [XLEN-1:0]    r_tgt [ENTRIES];
   ctr2_t              r_ctr [ENTRIES];

   logic [IDX_W-1:0] w_fetch_idx;
   logic [TAG_W-1:0] w_fetch_tag;
   logic             w_fetch_hit;
   logic [IDX_W-1:0] w_upd_idx;
   logic [TAG_W-1:0] w_upd_tag;
   logic             w_upd_hit;
   logic             w_pred_taken;
   logic             w_tgt_wrong;

   assign w_fetch_idx = IDX_W'(bp_idx(pc_wide_t'(fetch_pc), IDX_W));
   assign w_fetch_tag = TAG_W'(bp_tag(pc_wide_t'(fetch_pc), IDX_W, TAG_W));
   assign w_upd_idx   = IDX_W'(bp_idx(pc_wide_t'(upd_pc), IDX_W));
   assign w_upd_tag   = TAG_W'(bp_tag(pc_wide_t'(upd_pc), IDX_W, TAG_W));

   assign w_fetch_hit = r_valid[w_fetch_idx] && (r_tag[w_fetch_idx] == w_fetch_tag);
   assign w_upd_hit   = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

   // Valid bits are held clear by the asynchronous reset, so lookups miss while in reset.
   assign w_pred_taken = (MODE == 1) && w_fetch_hit && r_ctr[w_fetch_idx][1];
   assign pred_taken   = w_pred_taken;
   assign pred_target  = w_pred_taken ? r_tgt[w_fetch_idx] : fetch_pc + XLEN'(4);

   assign w_tgt_wrong = upd_taken && upd_pred_taken && (upd_target != upd_pred_target);
   assign mispredict  = upd_valid && ((upd_taken != upd_pred_taken) || w_tgt_wrong);
   assign redirect_pc = upd_taken ? upd_target : upd_pc + XLEN'(4);

   // NOTE: the arrays are flops, not a macro, so resetting every entry is legal and required here.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            r_tag[i] <= '0;
            r_tgt[i] <= '0;
            r_ctr[i] <= CTR_INIT;
         end
      end else if (flush_all) begin
         r_valid <= '0;
      end else if (upd_valid) begin
         if (upd_taken) begin
            if (!w_upd_hit) begin
               r_valid[w_upd_idx] <= 1'b1;
               r_tag[w_upd_idx]   <= w_upd_tag;
               r_tgt[w_upd_idx]   <= upd_target;
               r_ctr[w_upd_idx]   <= WT;
            end else begin
               r_tgt[w_upd_idx] <= upd_target;
               r_ctr[w_upd_idx] <= sat_inc2(r_ctr[w_upd_idx]);
            end
         end else if (w_upd_hit) begin
            r_ctr[w_upd_idx] <= sat_dec2(r_ctr[w_upd_idx]);
         end
      end
   end

   bp_sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
      .clk     (clk),
      .rst_n   (reset),
      .i_inc   (upd_valid),
      .i_clr   (clr_stats),
      .o_count (branch_count)
   );

   bp_sat_counter #(.CNT_W(CNT_W)) u_mispredict_cnt (
      .clk     (clk),
      .rst_n   (reset),
      .i_inc   (mispredict),
      .i_clr   (clr_stats),
      .o_count (mispredict_count)
   );

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Bench for branch_predictor_btb: a dynamic/32-bit-stats instance and a static/4-bit-stats
// instance share stimulus; a per-cycle model compare plus directed literal checks.
module tb_branch_predictor_btb;

   localparam int XLEN    = 64;
   localparam int ENTRIES = 16;
   localparam int TAG_W   = 8;
   localparam int CW_A    = 32;
   localparam int CW_B    = 4;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [XLEN-1:0] fetch_pc = '0;
   logic            upd_valid = 1'b0;
   logic [XLEN-1:0] upd_pc = '0;
   logic            upd_taken = 1'b0;
   logic [XLEN-1:0] upd_target = '0;
   logic            upd_pred_taken = 1'b0;
   logic [XLEN-1:0] upd_pred_target = '0;
   logic            flush_all = 1'b0;
   logic            clr_stats = 1'b0;

   logic            a_pred_taken, b_pred_taken;
   logic [XLEN-1:0] a_pred_target, b_pred_target;
   logic            a_mispredict, b_mispredict;
   logic [XLEN-1:0] a_redirect_pc, b_redirect_pc;
   logic [CW_A-1:0] a_branch_count, a_mispredict_count;
   logic [CW_B-1:0] b_branch_count, b_mispredict_count;

   always #5 clk = ~clk;

   branch_predictor_btb #(.XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_W(TAG_W), .MODE(1),
                          .CTR_INIT(2'b01), .CNT_W(CW_A)) u_dut_a (
      .clk(clk), .reset(reset), .fetch_pc(fetch_pc),
      .pred_taken(a_pred_taken), .pred_target(a_pred_target),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
      .upd_pred_target(upd_pred_target),
      .mispredict(a_mispredict), .redirect_pc(a_redirect_pc),
      .flush_all(flush_all), .clr_stats(clr_stats),
      .branch_count(a_branch_count), .mispredict_count(a_mispredict_count)
   );

   branch_predictor_btb #(.XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_W(TAG_W), .MODE(0),
                          .CTR_INIT(2'b01), .CNT_W(CW_B)) u_dut_b (
      .clk(clk), .reset(reset), .fetch_pc(fetch_pc),
      .pred_taken(b_pred_taken), .pred_target(b_pred_target),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
      .upd_pred_target(upd_pred_target),
      .mispredict(b_mispredict), .redirect_pc(b_redirect_pc),
      .flush_all(flush_all), .clr_stats(clr_stats),
      .branch_count(b_branch_count), .mispredict_count(b_mispredict_count)
   );

   int n_vec = 0;
   int n_mis = 0;
   bit done = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit              m_valid [ENTRIES];
   longint unsigned m_tag   [ENTRIES];
   longint unsigned m_tgt   [ENTRIES];
   int              m_ctr   [ENTRIES];
   longint unsigned raw_bc, raw_mc;

   function automatic int idx_of(input longint unsigned pc);
      return int'((pc / 4) % ENTRIES);
   endfunction

   function automatic longint unsigned tag_of(input longint unsigned pc);
      return (pc / (4 * ENTRIES)) % (longint'(1) << TAG_W);
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_valid[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
      end
      raw_bc = 0; raw_mc = 0;
   endfunction

   function automatic bit m_hit(input longint unsigned pc);
      return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
   endfunction

   function automatic bit m_taken(input longint unsigned pc, input int mode);
      return (mode == 1) && m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
   endfunction

   function automatic longint unsigned m_target(input longint unsigned pc, input int mode);
      return m_taken(pc, mode) ? m_tgt[idx_of(pc)] : pc + 4;
   endfunction

   function automatic bit m_mispredict();
      if (!upd_valid) return 1'b0;
      if (upd_taken != upd_pred_taken) return 1'b1;
      return upd_taken && (upd_target != upd_pred_target);
   endfunction

   function automatic longint unsigned sat(input longint unsigned raw, input int w);
      longint unsigned mx;
      mx = (longint'(1) << w) - 1;
      return (raw > mx) ? mx : raw;
   endfunction

   function automatic void model_step();
      int i;
      bit mis;
      mis = m_mispredict();
      if (flush_all) begin
         for (int k = 0; k < ENTRIES; k++) m_valid[k] = 1'b0;
      end else if (upd_valid) begin
         i = idx_of(upd_pc);
         if (upd_taken) begin
            if (!m_hit(upd_pc)) begin
               m_valid[i] = 1'b1; m_tag[i] = tag_of(upd_pc); m_tgt[i] = upd_target; m_ctr[i] = 2;
            end else begin
               m_tgt[i] = upd_target;
               if (m_ctr[i] < 3) m_ctr[i]++;
            end
         end else if (m_hit(upd_pc)) begin
            if (m_ctr[i] > 0) m_ctr[i]--;
         end
      end
      if (clr_stats) begin
         raw_bc = 0; raw_mc = 0;
      end else begin
         raw_bc += upd_valid;
         raw_mc += mis;
      end
   endfunction

   // Per-cycle compare against the model, sampled on the falling edge.
   initial begin
      model_reset();
      while (!done) begin
         @(negedge clk);
         if (done) break;
         if (!reset) model_reset();
         check("a_pred_taken",  a_pred_taken,  m_taken(fetch_pc, 1));
         check("a_pred_target", a_pred_target, m_target(fetch_pc, 1));
         check("b_pred_taken",  b_pred_taken,  m_taken(fetch_pc, 0));
         check("b_pred_target", b_pred_target, m_target(fetch_pc, 0));
         check("a_branch_count", a_branch_count, sat(raw_bc, CW_A));
         check("a_mispred_count", a_mispredict_count, sat(raw_mc, CW_A));
         check("b_branch_count", b_branch_count, sat(raw_bc, CW_B));
         check("b_mispred_count", b_mispredict_count, sat(raw_mc, CW_B));
         if (upd_valid) begin
            check("a_mispredict", a_mispredict, m_mispredict());
            check("b_mispredict", b_mispredict, m_mispredict());
            check("a_redirect_pc", a_redirect_pc, upd_taken ? upd_target : upd_pc + 4);
         end
         @(posedge clk);
         if (!reset) model_reset();
         else model_step();
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic upd(input logic [63:0] pc, input logic tk, input logic [63:0] tgt,
                      input logic ptk, input logic [63:0] ptgt);
      upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
      upd_pred_taken = ptk; upd_pred_target = ptgt;
   endtask

   task automatic no_upd();
      upd_valid = 1'b0;
   endtask

   initial begin
      fetch_pc = 64'h100;
      tick(); tick();
      #1;
      check("rst_pred_taken", a_pred_taken, 0);
      check("rst_pred_target", a_pred_target, 64'h104);
      check("rst_branch_count", a_branch_count, 0);
      reset = 1'b1;

      tick();
      upd(64'h100, 1, 64'h80, 0, 64'h104);
      #1;
      check("first_mispredict", a_mispredict, 1);
      check("first_redirect", a_redirect_pc, 64'h80);
      check("no_bypass_pred", a_pred_taken, 0);
      tick(); no_upd();
      #1;
      check("trained_pred", a_pred_taken, 1);
      check("trained_target", a_pred_target, 64'h80);
      check("trained_mcount", a_mispredict_count, 1);

      upd(64'h100, 1, 64'h80, 1, 64'h80);
      tick();
      tick();
      upd(64'h100, 0, 64'h80, 1, 64'h80);
      #1;
      check("nt_mispredict", a_mispredict, 1);
      check("nt_redirect", a_redirect_pc, 64'h104);
      tick(); no_upd();
      #1;
      check("wt_pred", a_pred_taken, 1);
      upd(64'h100, 0, 64'h80, 1, 64'h80);
      tick(); no_upd();
      #1;
      check("wnt_pred", a_pred_taken, 0);
      check("walk_bcount", a_branch_count, 5);
      check("walk_mcount", a_mispredict_count, 3);
      check("static_pred", b_pred_taken, 0);

      upd(64'h100, 1, 64'h80, 0, 64'h104);
      tick(); no_upd();
      #1;
      check("retrain_pred", a_pred_taken, 1);
      fetch_pc = 64'h500;
      #1;
      check("alias_miss", a_pred_taken, 0);
      check("alias_target", a_pred_target, 64'h504);
      upd(64'h500, 1, 64'h300, 0, 64'h504);
      tick(); no_upd();
      fetch_pc = 64'h100;
      #1;
      check("evicted_target", a_pred_target, 64'h104);
      fetch_pc = 64'h500;
      #1;
      check("alias_hit_target", a_pred_target, 64'h300);

      upd(64'h500, 1, 64'h340, 1, 64'h300);
      #1;
      check("tgt_mispredict", a_mispredict, 1);
      check("tgt_redirect", a_redirect_pc, 64'h340);
      tick(); no_upd();
      #1;
      check("retarget", a_pred_target, 64'h340);

      flush_all = 1'b1;
      upd(64'h200, 1, 64'h40, 0, 64'h204);
      tick(); no_upd(); flush_all = 1'b0;
      fetch_pc = 64'h200;
      #1;
      check("flush_drop", a_pred_target, 64'h204);
      fetch_pc = 64'h500;
      #1;
      check("flush_miss", a_pred_taken, 0);

      fetch_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      upd(64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 0, 64'h0);
      #1;
      check("wrap_target", a_pred_target, 64'h0);
      check("wrap_redirect", a_redirect_pc, 64'h0);
      check("wrap_no_mispredict", a_mispredict, 0);
      tick(); no_upd();

      clr_stats = 1'b1;
      upd(64'h700, 0, 64'h0, 0, 64'h704);
      tick(); no_upd(); clr_stats = 1'b0;
      #1;
      check("clr_bcount", a_branch_count, 0);

      for (int i = 0; i < 20; i++) begin
         upd(64'h600, 0, 64'h0, 0, 64'h604);
         tick();
      end
      no_upd();
      #1;
      check("sat_b_bcount", b_branch_count, 15);
      check("sat_a_bcount", a_branch_count, 20);

      upd(64'h500, 1, 64'h300, 0, 64'h504);
      tick(); no_upd();
      fetch_pc = 64'h500;
      #1;
      check("pre_rst_pred", a_pred_taken, 1);
      upd(64'h500, 1, 64'h300, 0, 64'h504);
      reset = 1'b0;
      #1;
      check("mid_rst_pred", a_pred_taken, 0);
      check("mid_rst_target", a_pred_target, 64'h504);
      check("mid_rst_bcount", a_branch_count, 0);
      check("mid_rst_mispredict", a_mispredict, 1);
      tick();
      reset = 1'b1;
      tick(); no_upd();
      #1;
      check("post_rst_pred", a_pred_taken, 1);
      check("post_rst_target", a_pred_target, 64'h300);
      check("post_rst_bcount", a_branch_count, 1);

      tick();
      done = 1'b1;
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
